// File: rtl/ha1_cipher_pkg.sv
// Shared types and helpers for the mod-26 letter cipher path.
package ha1_cipher_pkg;

  localparam int unsigned ALPHA = 26;
  localparam int unsigned LW    = 5;

  typedef logic [LW-1:0] letter_t;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_e;

  // Additive inverse mod 26; key letter 0 maps to 0 rather than 26.
  function automatic letter_t inv26(letter_t k);
    logic [LW:0] t;
    t = 6'(ALPHA) - {1'b0, k};
    return (k == '0) ? '0 : t[LW-1:0];
  endfunction

  function automatic logic is_legal(letter_t l);
    return 32'(l) < ALPHA;
  endfunction

endpackage

// File: rtl/ha1_key_regfile.sv
// Keyword storage: one synchronous write port, one asynchronous read port.
module ha1_key_regfile
  import ha1_cipher_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  letter_t       wdata_i,
  input  logic [AW-1:0] raddr_i,
  output letter_t       rdata_o
);

  letter_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ha1_vigenere_key_seq.sv
// Vigenere key sequencer: loads a keyword, then pairs each plaintext letter
// with the cycling key letter (or its mod-26 inverse) for the downstream adder.
module ha1_vigenere_key_seq
  import ha1_cipher_pkg::*;
#(
  parameter int unsigned MAX_KEY_LEN = 8,
  parameter int unsigned LW          = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_load,
  input  logic          key_valid,
  input  logic [LW-1:0] key_in,
  input  logic          key_last,
  output logic          key_ready,
  input  logic          decrypt,
  input  logic          resync,
  input  logic          p_valid,
  input  logic [LW-1:0] p_in,
  output logic          p_ready,
  output logic          out_valid,
  output logic [LW-1:0] out_P,
  output logic [LW-1:0] out_K,
  input  logic          out_ready,
  output logic          err
);

  localparam int unsigned PW = $clog2(MAX_KEY_LEN) + 1;
  localparam int unsigned IW = $clog2(MAX_KEY_LEN);

  state_e        state_q, state_d;
  logic [PW-1:0] key_len_q, key_len_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  letter_t       out_p_q, out_p_d;
  letter_t       out_k_q, out_k_d;
  logic          err_q, err_d;

  logic          key_we;
  logic [PW-1:0] rd_ptr;
  letter_t       key_rd;
  logic          p_ready_w;
  logic          accept;

  assign p_ready_w = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = p_valid && p_ready_w;
  // resync redirects the read of the letter accepted in the same cycle
  assign rd_ptr    = resync ? '0 : ptr_q;

  ha1_key_regfile #(
    .DEPTH (MAX_KEY_LEN),
    .AW    (IW)
  ) u_keys (
    .clk     (clk),
    .we_i    (key_we),
    .waddr_i (key_len_q[IW-1:0]),
    .wdata_i (key_in),
    .raddr_i (rd_ptr[IW-1:0]),
    .rdata_o (key_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      key_len_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_k_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_len_q   <= key_len_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_k_q     <= out_k_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_len_d   = key_len_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_k_d     = out_k_q;
    err_d       = err_q;
    key_we      = 1'b0;

    if (out_ready) out_valid_d = 1'b0;
    if (resync)    ptr_d       = '0;

    if (key_load) begin
      state_d     = LOAD;
      key_len_d   = '0;
      ptr_d       = '0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: ;
        LOAD: begin
          if (key_valid) begin
            if (!is_legal(key_in)) begin
              err_d = 1'b1;
              if (key_last) state_d = (key_len_q != '0) ? RUN : EMPTY;
            end else begin
              key_we    = 1'b1;
              key_len_d = key_len_q + PW'(1);
              if (key_last || key_len_q == PW'(MAX_KEY_LEN - 1)) state_d = RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            // accept implies the old pair is gone, so out_valid_d is already 0
            if (!is_legal(p_in)) begin
              err_d = 1'b1;
            end else begin
              out_valid_d = 1'b1;
              out_p_d     = p_in;
              out_k_d     = decrypt ? inv26(key_rd) : key_rd;
              ptr_d       = (rd_ptr == key_len_q - PW'(1)) ? '0 : rd_ptr + PW'(1);
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign key_ready = (state_q == LOAD);
  assign p_ready   = p_ready_w;
  assign out_valid = out_valid_q;
  assign out_P     = out_p_q;
  assign out_K     = out_k_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ha1_vigenere_key_seq.sv
// Directed bench for the Vigenere key sequencer with hand-computed expectations.
module tb_ha1_vigenere_key_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_load, key_valid, key_last, key_ready;
  logic [4:0] key_in;
  logic       decrypt, resync, p_valid, p_ready;
  logic [4:0] p_in;
  logic       out_valid, out_ready, err;
  logic [4:0] out_P, out_K;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          keybuf [16];

  ha1_vigenere_key_seq #(.MAX_KEY_LEN(8), .LW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_last  (key_last),
    .key_ready (key_ready),
    .decrypt   (decrypt),
    .resync    (resync),
    .p_valid   (p_valid),
    .p_in      (p_in),
    .p_ready   (p_ready),
    .out_valid (out_valid),
    .out_P     (out_P),
    .out_K     (out_K),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int n, input bit use_last);
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_in    = 5'(keybuf[i]);
      key_last  = use_last && (i == n - 1);
      step();
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_load = 0; key_valid = 0; key_in = '0; key_last = 0;
    decrypt = 0; resync = 0; p_valid = 0; p_in = '0; out_ready = 0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_P !== 5'd0)     begin bad++; $display("FAIL rst_out_P got=%0d exp=0", out_P); end
    total++; if (out_K !== 5'd0)     begin bad++; $display("FAIL rst_out_K got=%0d exp=0", out_K); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL rst_key_ready got=%0b exp=0", key_ready); end
    total++; if (p_ready !== 1'b0)   begin bad++; $display("FAIL rst_p_ready got=%0b exp=0", p_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_encrypt();
    int pt [5] = '{7, 4, 11, 11, 14};
    int ek [5] = '{10, 4, 24, 10, 4};
    int ct [5] = '{17, 8, 9, 21, 18};
    int sum;
    keybuf[0] = 10; keybuf[1] = 4; keybuf[2] = 24;
    load_key(3, 1'b1);
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL enc_key_ready got=%0b exp=0", key_ready); end
    total++; if (p_ready !== 1'b1)   begin bad++; $display("FAIL enc_p_ready got=%0b exp=1", p_ready); end
    out_ready = 1'b1;
    decrypt   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p_valid = 1'b1;
      p_in    = 5'(pt[i]);
      step();
      sum = (int'(out_P) + int'(out_K)) % 26;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL enc_valid[%0d] got=%0b exp=1", i, out_valid); end
      total++; if (out_P !== 5'(pt[i])) begin bad++; $display("FAIL enc_P[%0d] got=%0d exp=%0d", i, out_P, pt[i]); end
      total++; if (out_K !== 5'(ek[i])) begin bad++; $display("FAIL enc_K[%0d] got=%0d exp=%0d", i, out_K, ek[i]); end
      total++; if (sum != ct[i])        begin bad++; $display("FAIL enc_C[%0d] got=%0d exp=%0d", i, sum, ct[i]); end
    end
    p_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL enc_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    p_valid   = 1'b1;
    p_in      = 5'd3;
    out_ready = 1'b0;
    step();
    p_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%0b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_P !== 5'd0)     begin bad++; $display("FAIL mid_out_P got=%0d exp=0", out_P); end
    total++; if (out_K !== 5'd0)     begin bad++; $display("FAIL mid_out_K got=%0d exp=0", out_K); end
    total++; if (p_ready !== 1'b0)   begin bad++; $display("FAIL mid_p_ready got=%0b exp=0", p_ready); end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (p_ready !== 1'b0)   begin bad++; $display("FAIL mid_empty_p_ready got=%0b exp=0", p_ready); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL mid_empty_key_ready got=%0b exp=0", key_ready); end
  endtask

  task automatic test_decrypt();
    int ct [5] = '{17, 8, 9, 21, 18};
    int dk [5] = '{16, 22, 2, 16, 22};
    int pt [5] = '{7, 4, 11, 11, 14};
    int sum;
    keybuf[0] = 10; keybuf[1] = 4; keybuf[2] = 24;
    load_key(3, 1'b1);
    out_ready = 1'b1;
    decrypt   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p_valid = 1'b1;
      p_in    = 5'(ct[i]);
      step();
      sum = (int'(out_P) + int'(out_K)) % 26;
      total++; if (out_K !== 5'(dk[i])) begin bad++; $display("FAIL dec_K[%0d] got=%0d exp=%0d", i, out_K, dk[i]); end
      total++; if (sum != pt[i])        begin bad++; $display("FAIL dec_P[%0d] got=%0d exp=%0d", i, sum, pt[i]); end
    end
    p_valid = 1'b0;
    decrypt = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int pt [5] = '{7, 4, 11, 11, 14};
    int ek [5] = '{10, 4, 24, 10, 4};
    keybuf[0] = 10; keybuf[1] = 4; keybuf[2] = 24;
    load_key(3, 1'b1);
    out_ready = 1'b1;
    p_valid   = 1'b1;
    p_in      = 5'(pt[0]);
    step();
    out_ready = 1'b0;
    p_in      = 5'(pt[1]);
    for (int c = 0; c < 3; c++) begin
      #0;
      total++; if (p_ready !== 1'b0) begin bad++; $display("FAIL bp_p_ready[%0d] got=%0b exp=0", c, p_ready); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b exp=1", c, out_valid); end
      total++; if (out_P !== 5'd7 || out_K !== 5'd10)
        begin bad++; $display("FAIL bp_hold[%0d] got=P%0d/K%0d exp=P7/K10", c, out_P, out_K); end
    end
    out_ready = 1'b1;
    #0;
    total++; if (p_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b exp=1", p_ready); end
    for (int i = 1; i < 5; i++) begin
      p_in = 5'(pt[i]);
      step();
      total++; if (out_valid !== 1'b1 || out_P !== 5'(pt[i]) || out_K !== 5'(ek[i]))
        begin bad++; $display("FAIL bp_stream[%0d] got=v%0b P%0d K%0d exp=v1 P%0d K%0d", i, out_valid, out_P, out_K, pt[i], ek[i]); end
    end
    p_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_boundaries();
    int kv [8]  = '{0, 11, 12, 13, 14, 15, 16, 25};
    int ek [9]  = '{0, 11, 12, 13, 14, 15, 16, 25, 0};
    int dk [4]  = '{15, 14, 0, 15};
    for (int i = 0; i < 8; i++) keybuf[i] = kv[i];
    load_key(8, 1'b0);
    total++; if (key_ready !== 1'b0 || p_ready !== 1'b1)
      begin bad++; $display("FAIL full_key_run got=kr%0b pr%0b exp=kr0 pr1", key_ready, p_ready); end
    out_ready = 1'b1;
    decrypt   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      p_valid = 1'b1;
      p_in    = 5'(i);
      step();
      total++; if (out_K !== 5'(ek[i])) begin bad++; $display("FAIL wrap_K[%0d] got=%0d exp=%0d", i, out_K, ek[i]); end
    end
    decrypt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_in   = 5'(i);
      resync = (i == 2);
      step();
      total++; if (out_K !== 5'(dk[i])) begin bad++; $display("FAIL resync_K[%0d] got=%0d exp=%0d", i, out_K, dk[i]); end
    end
    resync  = 1'b0;
    p_valid = 1'b0;
    decrypt = 1'b0;
    step();
    keybuf[0] = 5;
    load_key(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      p_valid = 1'b1;
      p_in    = 5'(i + 1);
      decrypt = (i == 3);
      step();
      total++; if (out_K !== ((i == 3) ? 5'd21 : 5'd5))
        begin bad++; $display("FAIL single_K[%0d] got=%0d exp=%0d", i, out_K, (i == 3) ? 21 : 5); end
    end
    p_valid = 1'b0;
    decrypt = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    int ek [3] = '{2, 6, 2};
    keybuf[0] = 2; keybuf[1] = 27; keybuf[2] = 6;
    load_key(3, 1'b1);
    total++; if (err !== 1'b1)       begin bad++; $display("FAIL ill_key_err got=%0b exp=1", err); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL ill_key_run got=%0b exp=0", key_ready); end
    out_ready = 1'b1;
    p_valid   = 1'b1;
    p_in      = 5'd1;
    step();
    total++; if (out_K !== 5'(ek[0])) begin bad++; $display("FAIL ill_K0 got=%0d exp=%0d", out_K, ek[0]); end
    p_in = 5'd30;
    #0;
    total++; if (p_ready !== 1'b1) begin bad++; $display("FAIL ill_p_accept got=%0b exp=1", p_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_p_dropped got=%0b exp=0", out_valid); end
    total++; if (err !== 1'b1)       begin bad++; $display("FAIL ill_p_err got=%0b exp=1", err); end
    for (int i = 1; i < 3; i++) begin
      p_in = 5'd1;
      step();
      total++; if (out_valid !== 1'b1 || out_K !== 5'(ek[i]))
        begin bad++; $display("FAIL ill_K[%0d] got=v%0b K%0d exp=v1 K%0d", i, out_valid, out_K, ek[i]); end
    end
    p_valid  = 1'b0;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL ill_clear_err got=%0b exp=0", err); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL ill_reload got=%0b exp=1", key_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_reload_valid got=%0b exp=0", out_valid); end
    key_valid = 1'b1;
    key_in    = 5'd27;
    key_last  = 1'b1;
    step();
    key_valid = 1'b0;
    key_last  = 1'b0;
    total++; if (key_ready !== 1'b0 || p_ready !== 1'b0)
      begin bad++; $display("FAIL ill_empty got=kr%0b pr%0b exp=kr0 pr0", key_ready, p_ready); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_empty_err got=%0b exp=1", err); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_reset_midstream();
    test_decrypt();
    test_backpressure();
    test_boundaries();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
